// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm clock mode sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2,
    RING      = 2'd3
  } state_t;

  localparam int SEC_MAX = 9;
  localparam int MIN_MAX = 5;
  localparam int SEC_W   = 4;
  localparam int MIN_W   = 3;

endpackage

// File: rtl/alarm_controller_rise_edge.sv
// Registered rising-edge detector; history resets high so a level held
// through reset release is not seen as an edge.
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      hist  <= d;
      pulse <= d & ~hist;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock mode sequencer: run / set-time / set-alarm, plus ringing with
// auto-timeout and snooze.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_TICKS   = 30,
  parameter int SNOOZE_TICKS = 5
) (
  input  logic             signal,
  input  logic             reset_n,
  input  logic             mode_btn,
  input  logic             snooze_btn,
  input  logic             alarm_en_sw,
  input  logic             sec_tick,
  input  logic [MIN_W-1:0] cur_minutes,
  input  logic [SEC_W-1:0] cur_seconds,
  input  logic [MIN_W-1:0] alarm_minutes,
  input  logic [SEC_W-1:0] alarm_seconds,
  output logic             load_time,
  output logic             load_alarm,
  output logic [1:0]       mode,
  output logic             ringing,
  output logic             armed
);

  localparam int RW = $clog2(RING_TICKS + 1);
  localparam int SW = $clog2(SNOOZE_TICKS + 1);

  state_t          state, state_nx;
  logic [RW-1:0]   ring_cnt, ring_nx;
  logic [SW-1:0]   snooze_cnt, snooze_nx;
  logic            snooze_pend, pend_nx;
  logic            sec_tick_d;
  logic            mode_e, snooze_e;
  logic            match;

  rise_edge u_mode_edge (
    .clk   (signal),
    .rst_n (reset_n),
    .d     (mode_btn),
    .pulse (mode_e)
  );

  rise_edge u_snooze_edge (
    .clk   (signal),
    .rst_n (reset_n),
    .d     (snooze_btn),
    .pulse (snooze_e)
  );

  // Delayed tick so the compare sees the time after it has advanced.
  assign match = sec_tick_d & armed &
                 (cur_minutes == alarm_minutes) &
                 (cur_seconds == alarm_seconds);

  always_ff @(posedge signal or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      ring_cnt    <= '0;
      snooze_cnt  <= '0;
      snooze_pend <= 1'b0;
      sec_tick_d  <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state       <= state_nx;
      ring_cnt    <= ring_nx;
      snooze_cnt  <= snooze_nx;
      snooze_pend <= pend_nx;
      sec_tick_d  <= sec_tick;
      armed       <= alarm_en_sw;
    end
  end

  always_comb begin
    state_nx  = state;
    ring_nx   = ring_cnt;
    snooze_nx = snooze_cnt;
    pend_nx   = snooze_pend;
    case (state)
      RUN: begin
        if (mode_e) begin
          state_nx  = SET_TIME;
          pend_nx   = 1'b0;
          snooze_nx = '0;
        end else if (match) begin
          state_nx  = RING;
          ring_nx   = '0;
          pend_nx   = 1'b0;
          snooze_nx = '0;
        end else if (snooze_pend && sec_tick) begin
          if (snooze_cnt <= SW'(1)) begin
            pend_nx   = 1'b0;
            snooze_nx = '0;
            if (armed) begin
              state_nx = RING;
              ring_nx  = '0;
            end
          end else begin
            snooze_nx = snooze_cnt - 1'b1;
          end
        end
      end
      SET_TIME: begin
        if (mode_e) state_nx = SET_ALARM;
      end
      SET_ALARM: begin
        if (mode_e) state_nx = RUN;
      end
      RING: begin
        if (!armed || mode_e) begin
          state_nx  = RUN;
          pend_nx   = 1'b0;
          snooze_nx = '0;
        end else if (snooze_e) begin
          state_nx  = RUN;
          pend_nx   = 1'b1;
          snooze_nx = SW'(SNOOZE_TICKS);
        end else if (sec_tick) begin
          if (ring_cnt == RW'(RING_TICKS - 1)) state_nx = RUN;
          else                                 ring_nx  = ring_cnt + 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign load_time  = (state == SET_TIME);
  assign load_alarm = (state == SET_ALARM);
  assign ringing    = (state == RING);
  assign mode       = state;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with RING_TICKS=4, SNOOZE_TICKS=5.
module tb_alarm_controller;

  logic       signal = 1'b0;
  logic       reset_n;
  logic       mode_btn, snooze_btn, alarm_en_sw, sec_tick;
  logic [2:0] cur_minutes, alarm_minutes;
  logic [3:0] cur_seconds, alarm_seconds;
  logic       load_time, load_alarm, ringing, armed;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;

  alarm_controller #(.RING_TICKS(4), .SNOOZE_TICKS(5)) dut (
    .signal        (signal),
    .reset_n       (reset_n),
    .mode_btn      (mode_btn),
    .snooze_btn    (snooze_btn),
    .alarm_en_sw   (alarm_en_sw),
    .sec_tick      (sec_tick),
    .cur_minutes   (cur_minutes),
    .cur_seconds   (cur_seconds),
    .alarm_minutes (alarm_minutes),
    .alarm_seconds (alarm_seconds),
    .load_time     (load_time),
    .load_alarm    (load_alarm),
    .mode          (mode),
    .ringing       (ringing),
    .armed         (armed)
  );

  always #5 signal = ~signal;

  typedef struct {
    logic [2:0] tm0;
    logic [3:0] ts0;
    logic [2:0] am;
    logic [3:0] asec;
    logic       en;
    logic       exp_ring;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge signal);
    #1;
  endtask

  // Mimics the time counter: advances on the edge that consumes sec_tick.
  task automatic pulse_sec();
    sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0;
    if (cur_seconds == 4'd9) begin
      cur_seconds = 4'd0;
      cur_minutes = (cur_minutes >= 3'd5) ? 3'd0 : cur_minutes + 3'd1;
    end else begin
      cur_seconds = cur_seconds + 4'd1;
    end
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    tick();
    tick();
    mode_btn = 1'b0;
    tick();
  endtask

  task automatic ring_at_3_7();
    cur_minutes = 3'd3;
    cur_seconds = 4'd6;
    pulse_sec();
    chk("ring_not_yet", ringing, 0);
    tick();
    chk("ring_start", ringing, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd3, 4'd6,  3'd3, 4'd7,  1'b1, 1'b1};
    vecs[1] = '{3'd3, 4'd6,  3'd3, 4'd8,  1'b1, 1'b0};
    vecs[2] = '{3'd3, 4'd6,  3'd2, 4'd7,  1'b1, 1'b0};
    vecs[3] = '{3'd3, 4'd6,  3'd3, 4'd7,  1'b0, 1'b0};
    vecs[4] = '{3'd0, 4'd9,  3'd1, 4'd0,  1'b1, 1'b1};
    vecs[5] = '{3'd5, 4'd9,  3'd0, 4'd0,  1'b1, 1'b1};
    vecs[6] = '{3'd0, 4'd11, 3'd0, 4'd12, 1'b1, 1'b1};
    vecs[7] = '{3'd7, 4'd3,  3'd7, 4'd4,  1'b1, 1'b1};

    reset_n = 1'b0;
    mode_btn = 1'b1;
    snooze_btn = 1'b0;
    alarm_en_sw = 1'b0;
    sec_tick = 1'b0;
    cur_minutes = 3'd0;
    cur_seconds = 4'd0;
    alarm_minutes = 3'd3;
    alarm_seconds = 4'd7;

    // Mode button held through reset release must not register an edge.
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("rst_mode", mode, 0);
    chk("rst_load_time", load_time, 0);
    chk("rst_load_alarm", load_alarm, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_armed", armed, 0);
    mode_btn = 1'b0;
    alarm_en_sw = 1'b1;
    tick();
    tick();
    chk("armed_follow", armed, 1);

    press_mode();
    chk("cyc1_mode", mode, 1);
    chk("cyc1_lt", load_time, 1);
    chk("cyc1_la", load_alarm, 0);
    cur_minutes = 3'd3;
    cur_seconds = 4'd6;
    pulse_sec();
    tick();
    chk("settime_no_ring", ringing, 0);
    chk("settime_stay", mode, 1);
    press_mode();
    chk("cyc2_mode", mode, 2);
    chk("cyc2_lt", load_time, 0);
    chk("cyc2_la", load_alarm, 1);
    press_mode();
    chk("cyc3_mode", mode, 0);
    chk("cyc3_lt", load_time, 0);
    chk("cyc3_la", load_alarm, 0);

    for (int i = 0; i < 8; i++) begin
      alarm_minutes = vecs[i].am;
      alarm_seconds = vecs[i].asec;
      alarm_en_sw   = vecs[i].en;
      cur_minutes   = vecs[i].tm0;
      cur_seconds   = vecs[i].ts0;
      tick();
      tick();
      pulse_sec();
      tick();
      chk($sformatf("vec%0d_ring", i), ringing, vecs[i].exp_ring);
      if (ringing) press_mode();
      chk($sformatf("vec%0d_mode_after", i), mode, 0);
    end

    alarm_minutes = 3'd3;
    alarm_seconds = 4'd7;
    alarm_en_sw = 1'b1;
    tick();
    tick();

    // Auto-timeout on the 4th sec_tick after ringing starts.
    ring_at_3_7();
    for (int k = 1; k <= 3; k++) begin
      pulse_sec();
      chk($sformatf("timeout_hold%0d", k), ringing, 1);
    end
    pulse_sec();
    chk("timeout_stop", ringing, 0);
    chk("timeout_mode", mode, 0);

    // Snooze then re-ring on the 5th sec_tick.
    ring_at_3_7();
    snooze_btn = 1'b1;
    tick();
    tick();
    chk("snooze_stop", ringing, 0);
    snooze_btn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pulse_sec();
      chk($sformatf("snooze_wait%0d", k), ringing, 0);
    end
    pulse_sec();
    chk("snooze_rering", ringing, 1);

    // Mode press during snooze wait cancels the pending re-ring.
    snooze_btn = 1'b1;
    tick();
    tick();
    snooze_btn = 1'b0;
    chk("snooze2_stop", ringing, 0);
    pulse_sec();
    pulse_sec();
    press_mode();
    chk("snooze_cancel_mode", mode, 1);
    repeat (5) pulse_sec();
    chk("snooze_cancel_ring", ringing, 0);
    press_mode();
    press_mode();
    chk("back_to_run", mode, 0);
    repeat (6) pulse_sec();
    chk("snooze_cleared", ringing, 0);

    // Disarm while ringing, then matching time must not ring.
    ring_at_3_7();
    alarm_en_sw = 1'b0;
    tick();
    tick();
    chk("disarm_stop", ringing, 0);
    cur_minutes = 3'd3;
    cur_seconds = 4'd6;
    pulse_sec();
    tick();
    chk("disarm_no_ring", ringing, 0);
    alarm_en_sw = 1'b1;
    tick();
    tick();

    // mode_e coincident with match: mode wins.
    cur_minutes = 3'd3;
    cur_seconds = 4'd6;
    mode_btn = 1'b1;
    sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0;
    cur_seconds = 4'd7;
    tick();
    chk("simul_mode", mode, 1);
    chk("simul_ring", ringing, 0);
    mode_btn = 1'b0;
    tick();
    chk("simul_ring_later", ringing, 0);
    press_mode();
    press_mode();
    chk("simul_back_run", mode, 0);

    // Async reset mid-ring.
    ring_at_3_7();
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset_ring", ringing, 0);
    chk("areset_mode", mode, 0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("areset_after", mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
